// File: rtl/shooting_flags_pkg.sv
// Shared definitions for the shooting-flag LED link (sender and receiver).
package shooting_flags_pkg;

    localparam logic [7:0]  SYNC_BYTE  = 8'h67;
    localparam int unsigned FRAME_LEN  = 16;
    localparam int unsigned PWM_PERIOD = 5;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2
    } state_t;

    // Rotate left by k (slot k carries rotl8(byte, k mod 8)).
    function automatic logic [7:0] rotl8(input logic [7:0] b, input logic [2:0] k);
        logic [15:0] w;
        w = {b, b} << k;
        return w[15:8];
    endfunction

    // Rotate right by k, inverse of rotl8.
    function automatic logic [7:0] rotr8(input logic [7:0] b, input logic [2:0] k);
        logic [15:0] w;
        w = {b, b} >> k;
        return w[7:0];
    endfunction

endpackage

// File: rtl/pwm_level_recover.sv
// Strips the sender's PWM: ORs the bus over each PWM window into a stable
// symbol level and flags the cycle after the level changes.
module pwm_level_recover #(
    parameter int unsigned PWM_PERIOD = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cats_in,
    output logic [7:0] level,
    output logic       change
);

    localparam int unsigned    CW       = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [CW-1:0]  CTR_LAST = CW'(PWM_PERIOD - 1);

    logic [CW-1:0] ctr;
    logic [7:0]    acc;
    logic [7:0]    prev_level;

    // Free-running window counter; accumulated OR becomes the level at wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr        <= '0;
            acc        <= '0;
            level      <= '0;
            prev_level <= '0;
        end else begin
            prev_level <= level;
            if (ctr == CTR_LAST) begin
                ctr   <= '0;
                level <= acc | cats_in;
                acc   <= '0;
            end else begin
                ctr <= ctr + CW'(1);
                acc <= acc | cats_in;
            end
        end
    end

    assign change = (level != prev_level);

endmodule

// File: rtl/shooting_flags_rx.sv
// Receive end of the shooting-flag link: recovers slot timing from symbol
// edges, locks on the frame start byte, undoes per-slot rotation and
// presents bytes on a valid/ready stream.
module shooting_flags_rx #(
    parameter int unsigned CLK_FREQ    = 48_000_000,
    parameter int unsigned SLOT_CYCLES = CLK_FREQ / 2,
    parameter int unsigned PWM_PERIOD  = shooting_flags_pkg::PWM_PERIOD,
    parameter int unsigned FRAME_LEN   = shooting_flags_pkg::FRAME_LEN,
    parameter logic [7:0]  SYNC_BYTE   = shooting_flags_pkg::SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cats_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sof,
    output logic       locked,
    output logic       overflow,
    output logic       sync_err
);

    import shooting_flags_pkg::*;

    localparam int unsigned    IW          = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IW-1:0]  IDX_LAST    = IW'(FRAME_LEN - 1);
    localparam logic [IW-1:0]  IDX_ONE     = (FRAME_LEN > 1) ? IW'(1) : '0;
    localparam logic [31:0]    HALF_SLOT   = 32'(SLOT_CYCLES / 2);
    localparam logic [31:0]    SLOT_RELOAD = 32'(SLOT_CYCLES - 1);
    localparam logic [31:0]    LOST_LIMIT  = 32'(4 * SLOT_CYCLES - 1);

    state_t        state, state_n;
    logic [31:0]   slot_tmr, slot_tmr_n;
    logic [31:0]   quiet_tmr, quiet_tmr_n;
    logic [IW-1:0] idx, idx_n;
    logic          locked_n;
    logic          sync_err_n;
    logic          slot_hit;
    logic          emit;
    logic          emit_sof;
    logic [7:0]    emit_data;
    logic          load;

    logic [7:0]    level;
    logic          change;
    logic [2:0]    rot_k;
    logic [7:0]    derot;

    pwm_level_recover #(
        .PWM_PERIOD (PWM_PERIOD)
    ) u_level (
        .clk     (clk),
        .rst_n   (rst_n),
        .cats_in (cats_in),
        .level   (level),
        .change  (change)
    );

    assign rot_k = 3'(idx);
    assign derot = rotr8(level, rot_k);

    // State, slot timer, quiet timer, slot index and lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            slot_tmr  <= '0;
            quiet_tmr <= '0;
            idx       <= '0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_n;
            slot_tmr  <= slot_tmr_n;
            quiet_tmr <= quiet_tmr_n;
            idx       <= idx_n;
            locked    <= locked_n;
            sync_err  <= sync_err_n;
        end
    end

    // Slot timing recovery, frame alignment and byte de-rotation.
    always_comb begin
        state_n     = state;
        slot_tmr_n  = slot_tmr;
        quiet_tmr_n = quiet_tmr;
        idx_n       = idx;
        locked_n    = locked;
        sync_err_n  = 1'b0;
        slot_hit    = 1'b0;
        emit        = 1'b0;
        emit_sof    = 1'b0;
        emit_data   = derot;

        unique case (state)
            HUNT: begin
                slot_tmr_n  = '0;
                quiet_tmr_n = '0;
                idx_n       = '0;
                if (change) begin
                    slot_tmr_n = HALF_SLOT;
                    state_n    = SEARCH;
                end
            end

            SEARCH, TRACK: begin
                // An edge re-centres the sampling point and wins over expiry.
                if (change) begin
                    slot_tmr_n  = HALF_SLOT;
                    quiet_tmr_n = '0;
                end else begin
                    quiet_tmr_n = quiet_tmr + 32'd1;
                    if (slot_tmr == '0) begin
                        slot_hit   = 1'b1;
                        slot_tmr_n = SLOT_RELOAD;
                    end else begin
                        slot_tmr_n = slot_tmr - 32'd1;
                    end
                end

                if (!change && (quiet_tmr == LOST_LIMIT)) begin
                    state_n     = HUNT;
                    locked_n    = 1'b0;
                    idx_n       = '0;
                    slot_tmr_n  = '0;
                    quiet_tmr_n = '0;
                end else if (slot_hit) begin
                    if (state == SEARCH) begin
                        if (level == SYNC_BYTE) begin
                            emit      = 1'b1;
                            emit_sof  = 1'b1;
                            emit_data = SYNC_BYTE;
                            idx_n     = IDX_ONE;
                            locked_n  = 1'b1;
                            state_n   = TRACK;
                        end
                    end else begin
                        idx_n = (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
                        if (idx == '0) begin
                            if (derot != SYNC_BYTE) begin
                                sync_err_n = 1'b1;
                                locked_n   = 1'b0;
                                state_n    = SEARCH;
                            end else begin
                                emit     = 1'b1;
                                emit_sof = 1'b1;
                            end
                        end else begin
                            emit = 1'b1;
                        end
                    end
                end
            end

            default: state_n = HUNT;
        endcase
    end

    assign load = emit && (!out_valid || out_ready);

    // Output holding register; a byte arriving while it is still full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= emit && !load;
            if (load) begin
                out_data  <= emit_data;
                out_sof   <= emit_sof;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shooting_flags_rx.sv
// Directed bench for shooting_flags_rx: a sender model drives rotated,
// PWM-gated symbols; accepted bytes are compared with the known frame text.
module tb_shooting_flags_rx;

    localparam int SLOT = 40;
    localparam int PWM  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cats_in = 8'h00;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sof;
    logic       locked;
    logic       overflow;
    logic       sync_err;

    always #5 clk = ~clk;

    shooting_flags_rx #(
        .CLK_FREQ    (80),
        .SLOT_CYCLES (SLOT),
        .PWM_PERIOD  (PWM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cats_in   (cats_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .locked    (locked),
        .overflow  (overflow),
        .sync_err  (sync_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Monitor: accepted bytes and pulse counts, sampled mid-cycle.
    logic [8:0] cap[$];
    int         n_ovf = 0;
    int         n_serr = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) cap.push_back({out_sof, out_data});
            if (overflow) n_ovf++;
            if (sync_err) n_serr++;
        end
    end

    // Sender model.
    logic [7:0] fr_main [16];
    logic [7:0] fr_jit  [16];
    int         jit [16] = '{0, 3, -3, 2, -2, 1, -1, 3, -3, -3, 0, 3, 0, 2, -2, 1};
    int         sph = 0;
    logic [8:0] expq[$];

    function automatic logic [7:0] brotl(input logic [7:0] b, input int k);
        int r;
        r = k % 8;
        return 8'((b << r) | (b >> (8 - r)));
    endfunction

    task automatic send_sym(input logic [7:0] sym, input int len);
        for (int c = 0; c < len; c++) begin
            cats_in = (sph < 2) ? sym : 8'h00;
            sph = (sph == PWM - 1) ? 0 : sph + 1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_slot(input int k, input logic [7:0] b, input int len);
        send_sym(brotl(b, k), len);
    endtask

    task automatic send_frame_main();
        for (int k = 0; k < 16; k++) send_slot(k, fr_main[k], SLOT);
    endtask

    task automatic add_exp(input int which, input int from, input int to);
        for (int i = from; i <= to; i++)
            expq.push_back({(i == 0), (which == 0) ? fr_main[i] : fr_jit[i]});
    endtask

    task automatic chk_seq(input string tag, input int base);
        logic [31:0] got;
        chk({tag, "_count"}, cap.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            got = (base + i < cap.size()) ? 32'(cap[base + i]) : 32'hDEAD;
            chk($sformatf("%s_b%0d", tag, i), got, 32'(expq[i]));
        end
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        cats_in   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        string s;
        int base;
        int ovf0;
        int serr0;

        s = "gry{1_cat_1_bit}";
        for (int i = 0; i < 16; i++) begin
            fr_main[i] = s[i];
            fr_jit[i]  = s[i];
        end
        // Slot 10 shows the same symbol as slot 9: rotl(8'hAF,2) == rotl('_',1) == 8'hBE.
        fr_jit[10] = 8'hAF;

        // Reset state
        reset_dut();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sof", out_sof, 0);
        chk("rst_locked", locked, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sync_err", sync_err, 0);

        // 1: two clean frames
        base = cap.size(); ovf0 = n_ovf; serr0 = n_serr;
        send_slot(0, fr_main[0], 5);
        chk("t1_lock_pre", locked, 0);
        send_slot(0, fr_main[0], SLOT - 5);
        chk("t1_lock_g", locked, 1);
        chk("t1_first_cnt", cap.size() - base, 1);
        for (int k = 1; k < 16; k++) send_slot(k, fr_main[k], SLOT);
        send_frame_main();
        add_exp(0, 0, 15);
        add_exp(0, 0, 15);
        chk_seq("t1", base);
        chk("t1_ovf", n_ovf - ovf0, 0);
        chk("t1_serr", n_serr - serr0, 0);

        // 2: sender starts mid-frame
        reset_dut();
        base = cap.size(); ovf0 = n_ovf;
        for (int k = 5; k < 16; k++) send_slot(k, fr_main[k], SLOT);
        chk("t2_discard", cap.size() - base, 0);
        chk("t2_lock_pre", locked, 0);
        send_frame_main();
        add_exp(0, 0, 15);
        chk_seq("t2", base);
        chk("t2_locked", locked, 1);
        chk("t2_ovf", n_ovf - ovf0, 0);

        // 3: back-pressure over slots 2..4
        reset_dut();
        base = cap.size(); ovf0 = n_ovf;
        send_slot(0, fr_main[0], SLOT);
        send_slot(1, fr_main[1], SLOT);
        out_ready = 1'b0;
        for (int k = 2; k < 5; k++) begin
            send_slot(k, fr_main[k], SLOT);
            chk($sformatf("t3_hold_valid_s%0d", k), out_valid, 1);
            chk($sformatf("t3_hold_data_s%0d", k), out_data, 8'h79);
        end
        chk("t3_ovf_cnt", n_ovf - ovf0, 2);
        out_ready = 1'b1;
        for (int k = 5; k < 16; k++) send_slot(k, fr_main[k], SLOT);
        add_exp(0, 0, 2);
        add_exp(0, 5, 15);
        chk_seq("t3", base);
        chk("t3_ovf_final", n_ovf - ovf0, 2);

        // 4: corrupted slot 0 of frame 2
        reset_dut();
        base = cap.size(); serr0 = n_serr;
        send_frame_main();
        send_sym(8'h00, SLOT);
        chk("t4_unlocked", locked, 0);
        chk("t4_serr", n_serr - serr0, 1);
        for (int k = 1; k < 16; k++) send_slot(k, fr_main[k], SLOT);
        chk("t4_no_out", cap.size() - base, 16);
        send_frame_main();
        add_exp(0, 0, 15);
        add_exp(0, 0, 15);
        chk_seq("t4", base);
        chk("t4_relock", locked, 1);
        chk("t4_serr_final", n_serr - serr0, 1);

        // 5: repeated symbol across slots 9/10 with slot jitter
        reset_dut();
        base = cap.size(); ovf0 = n_ovf; serr0 = n_serr;
        for (int k = 0; k < 16; k++) send_slot(k, fr_jit[k], SLOT + jit[k]);
        for (int k = 0; k < 16; k++) send_slot(k, fr_jit[k], SLOT + jit[15 - k]);
        add_exp(1, 0, 15);
        add_exp(1, 0, 15);
        chk_seq("t5", base);
        chk("t5_ovf", n_ovf - ovf0, 0);
        chk("t5_serr", n_serr - serr0, 0);

        // 6: link loss, relock, then reset mid-slot 7
        reset_dut();
        base = cap.size(); serr0 = n_serr;
        send_frame_main();
        add_exp(0, 0, 15);
        send_sym(8'h00, 200);
        chk("t6_lost", locked, 0);
        chk("t6_serr", n_serr - serr0, 1);
        chk("t6_idle_cnt", cap.size() - base, 16);
        for (int k = 0; k < 7; k++) send_slot(k, fr_main[k], SLOT);
        add_exp(0, 0, 6);
        chk("t6_relock", locked, 1);
        out_ready = 1'b0;
        send_slot(7, fr_main[7], 36);
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_data", out_data, 8'h61);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_sof", out_sof, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_slot(7, fr_main[7], 2);
        for (int k = 8; k < 16; k++) send_slot(k, fr_main[k], SLOT);
        chk("t6_post_lock", locked, 0);
        send_frame_main();
        add_exp(0, 0, 15);
        chk_seq("t6", base);
        chk("t6_final_lock", locked, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
